tile_scheduler: RTL and testbench

Sequencer that runs a complete size×size int8 matrix multiply on the 2x2 tensor core. It walks output tiles (i,j) and reduction steps k, and fetches packed 2x2 A and B tiles over a single OBI-style memory port. It hands each A/B pair to the core's feeder through a valid/ready handshake, then collects each finished 2x2 result and writes it back. It sits between the Croc bus master port and the core datapath and owns the memory port exclusively.

---
 rtl/tile_sched_pkg.sv | 51 +++++
 rtl/tile_addr_gen.sv | 114 +++++++++++
 rtl/tile_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_tile_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_sched_pkg.sv
// Shared types and constants for the tile scheduler: FSM states, tile strides,
// and the layout of a 2x2 result tile in memory.
package tile_sched_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH_A  = 4'd1,
        WAIT_A   = 4'd2,
        FETCH_B  = 4'd3,
        WAIT_B   = 4'd4,
        ISSUE    = 4'd5,
        WAIT_RES = 4'd6,
        WRITE    = 4'd7,
        WRESP    = 4'd8,
        DONE     = 4'd9
    } state_t;

    localparam int TILE_BYTES  = 4;
    localparam int CTILE_BYTES = 16;

    localparam int C11_OFF = 0;
    localparam int C12_OFF = 4;
    localparam int C21_OFF = 8;
    localparam int C22_OFF = 12;

    typedef struct packed {
        logic [31:0] c11;
        logic [31:0] c12;
        logic [31:0] c21;
        logic [31:0] c22;
    } res_tile_t;

    function automatic logic [3:0] res_word_off(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'(C11_OFF);
            2'd1:    return 4'(C12_OFF);
            2'd2:    return 4'(C21_OFF);
            default: return 4'(C22_OFF);
        endcase
    endfunction

    function automatic logic [31:0] res_word_sel(input res_tile_t r, input logic [1:0] idx);
        case (idx)
            2'd0:    return r.c11;
            2'd1:    return r.c12;
            2'd2:    return r.c21;
            default: return r.c22;
        endcase
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Walks (i,j,k) over a TxT tile grid and keeps A/B/C addresses incrementally (no multipliers).
// Zero latency: addresses and last flags reflect the current step; advances only on step_k/step_tile.
module tile_addr_gen
    import tile_sched_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              step_k,
    input  logic              step_tile,
    input  logic [16:0]       tiles,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] c_base,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr,
    output logic              last_k,
    output logic              last_tile
);

    logic [16:0]       t_q, t_d;
    logic [16:0]       i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] b_base_q, b_base_d;
    logic [ADDR_W-1:0] a_ptr_q, a_ptr_d, a_row_q, a_row_d;
    logic [ADDR_W-1:0] b_ptr_q, b_ptr_d, b_col_q, b_col_d;
    logic [ADDR_W-1:0] c_ptr_q, c_ptr_d;

    assign a_addr    = a_ptr_q;
    assign b_addr    = b_ptr_q;
    assign c_addr    = c_ptr_q;
    assign last_k    = (k_q == t_q - 17'd1);
    assign last_tile = (i_q == t_q - 17'd1) && (j_q == t_q - 17'd1);

    always_comb begin
        t_d      = t_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        stride_d = stride_q;
        b_base_d = b_base_q;
        a_ptr_d  = a_ptr_q;
        a_row_d  = a_row_q;
        b_ptr_d  = b_ptr_q;
        b_col_d  = b_col_q;
        c_ptr_d  = c_ptr_q;
        if (init) begin
            t_d      = tiles;
            // One row of tile words is 4*T bytes
            stride_d = ADDR_W'({tiles, 2'b00});
            b_base_d = b_base;
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            a_ptr_d  = a_base;
            a_row_d  = a_base;
            b_ptr_d  = b_base;
            b_col_d  = b_base;
            c_ptr_d  = c_base;
        end else if (step_tile) begin
            k_d     = '0;
            c_ptr_d = c_ptr_q + ADDR_W'(CTILE_BYTES);
            if (j_q == t_q - 17'd1) begin
                j_d     = '0;
                i_d     = i_q + 17'd1;
                a_row_d = a_row_q + stride_q;
                a_ptr_d = a_row_q + stride_q;
                b_col_d = b_base_q;
                b_ptr_d = b_base_q;
            end else begin
                j_d     = j_q + 17'd1;
                a_ptr_d = a_row_q;
                b_col_d = b_col_q + ADDR_W'(TILE_BYTES);
                b_ptr_d = b_col_q + ADDR_W'(TILE_BYTES);
            end
        end else if (step_k) begin
            k_d     = k_q + 17'd1;
            a_ptr_d = a_ptr_q + ADDR_W'(TILE_BYTES);
            b_ptr_d = b_ptr_q + stride_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            stride_q <= '0;
            b_base_q <= '0;
            a_ptr_q  <= '0;
            a_row_q  <= '0;
            b_ptr_q  <= '0;
            b_col_q  <= '0;
            c_ptr_q  <= '0;
        end else begin
            t_q      <= t_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            stride_q <= stride_d;
            b_base_q <= b_base_d;
            a_ptr_q  <= a_ptr_d;
            a_row_q  <= a_row_d;
            b_ptr_q  <= b_ptr_d;
            b_col_q  <= b_col_d;
            c_ptr_q  <= c_ptr_d;
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// Sequences a full int8 matmul on the 2x2 core: fetch A/B tiles, hand pairs to the feeder, write C back.
// 5 cycles per k step, 8 per result write-back at zero wait; stalls in place on gnt/rvalid/ready/res_valid.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [17:0]       size,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] c_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [31:0]       pair_a,
    output logic [31:0]       pair_b,
    output logic              pair_last,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [31:0]       res_c11,
    input  logic [31:0]       res_c12,
    input  logic [31:0]       res_c21,
    input  logic [31:0]       res_c22
);

    state_t      state_q, state_d;
    logic [31:0] pair_a_q, pair_a_d;
    logic [31:0] pair_b_q, pair_b_d;
    res_tile_t   res_q, res_d;
    logic [1:0]  word_q, word_d;
    logic        err_q, err_d;

    logic              init, step_k, step_tile;
    logic              last_k, last_tile, size_bad;
    logic [ADDR_W-1:0] a_addr, b_addr, c_addr;

    assign size_bad = (size == 18'd0) || size[0];
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign pair_a   = pair_a_q;
    assign pair_b   = pair_b_q;

    tile_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .step_k    (step_k),
        .step_tile (step_tile),
        .tiles     (size[17:1]),
        .a_base    (a_base),
        .b_base    (b_base),
        .c_base    (c_base),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .c_addr    (c_addr),
        .last_k    (last_k),
        .last_tile (last_tile)
    );

    always_comb begin
        state_d    = state_q;
        pair_a_d   = pair_a_q;
        pair_b_d   = pair_b_q;
        res_d      = res_q;
        word_d     = word_q;
        err_d      = err_q;
        init       = 1'b0;
        step_k     = 1'b0;
        step_tile  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        pair_valid = 1'b0;
        pair_last  = 1'b0;
        res_ready  = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = size_bad;
                    if (size_bad) begin
                        state_d = DONE;
                    end else begin
                        init    = 1'b1;
                        state_d = FETCH_A;
                    end
                end
            end
            FETCH_A: begin
                mem_req  = 1'b1;
                mem_addr = a_addr;
                if (mem_gnt) state_d = WAIT_A;
            end
            WAIT_A: begin
                if (mem_rvalid) begin
                    pair_a_d = 32'(mem_rdata);
                    state_d  = FETCH_B;
                end
            end
            FETCH_B: begin
                mem_req  = 1'b1;
                mem_addr = b_addr;
                if (mem_gnt) state_d = WAIT_B;
            end
            WAIT_B: begin
                if (mem_rvalid) begin
                    pair_b_d = 32'(mem_rdata);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                pair_valid = 1'b1;
                pair_last  = last_k;
                if (pair_ready) begin
                    if (last_k) begin
                        state_d = WAIT_RES;
                    end else begin
                        step_k  = 1'b1;
                        state_d = FETCH_A;
                    end
                end
            end
            WAIT_RES: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    res_d   = '{c11: res_c11, c12: res_c12, c21: res_c21, c22: res_c22};
                    word_d  = 2'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = c_addr + ADDR_W'(res_word_off(word_q));
                mem_wdata = ADDR_W'(res_word_sel(res_q, word_q));
                if (mem_gnt) state_d = WRESP;
            end
            WRESP: begin
                if (mem_rvalid) begin
                    if (word_q == 2'd3) begin
                        if (last_tile) begin
                            state_d = DONE;
                        end else begin
                            step_tile = 1'b1;
                            state_d   = FETCH_A;
                        end
                    end else begin
                        word_d  = word_q + 2'd1;
                        state_d = WRITE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pair_a_q <= '0;
            pair_b_q <= '0;
            res_q    <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pair_a_q <= pair_a_d;
            pair_b_q <= pair_b_d;
            res_q    <= res_d;
            word_q   <= word_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler with memory and feeder responder models and scoreboards
// for the memory transaction order, tile pairs and write-back data.
module tb_tile_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic [17:0] size;
    logic [31:0] a_base, b_base, c_base;
    logic        busy, done, err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        pair_valid, pair_ready, pair_last;
    logic [31:0] pair_a, pair_b;
    logic        res_valid, res_ready;
    logic [31:0] res_c11, res_c12, res_c21, res_c22;

    tile_scheduler #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .size       (size),
        .a_base     (a_base),
        .b_base     (b_base),
        .c_base     (c_base),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_a     (pair_a),
        .pair_b     (pair_b),
        .pair_last  (pair_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_c11    (res_c11),
        .res_c12    (res_c12),
        .res_c21    (res_c21),
        .res_c22    (res_c22)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // {we, addr, wdata} for memory; {a, b, last} for pairs
    logic [64:0] exp_mem[$];
    logic [64:0] exp_pair[$];
    int          exp_tiles;

    int gnt_dly = 0, rv_dly = 0, rdy_dly = 0, res_dly = 0;
    int gnt_count = 0, res_n = 0, done_cnt = 0;

    int          req_wait = 0, rv_cnt = 0, rdy_wait = 0, res_cnt = 0;
    logic        rv_pend = 1'b0, res_pend = 1'b0;
    logic [31:0] rv_data;
    logic [64:0] hold_req, hold_pair;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_0001;
    endfunction

    // Memory responder: grants after gnt_dly stall cycles, responds rv_dly cycles after the earliest slot
    initial begin
        logic [64:0] obs, e;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_pend) begin
                check("req_while_outstanding", 65'(mem_req), 65'(0));
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rv_data;
                    rv_pend    = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (mem_req === 1'b1) begin
                obs = {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)};
                if (req_wait == 0) hold_req = obs;
                else check("req_stable", obs, hold_req);
                if (req_wait < gnt_dly) begin
                    req_wait++;
                end else begin
                    mem_gnt  = 1'b1;
                    req_wait = 0;
                    gnt_count++;
                    e = (exp_mem.size() != 0) ? exp_mem.pop_front() : '1;
                    check(mem_we ? "mem_write" : "mem_read", obs, e);
                    rv_pend = 1'b1;
                    rv_cnt  = rv_dly;
                    rv_data = mem_we ? 32'h0 : rd_fn(mem_addr);
                end
            end else if (req_wait != 0) begin
                check("req_dropped", 65'(mem_req), 65'(1));
                req_wait = 0;
            end
        end
    end

    // Feeder responder: accepts pairs after rdy_dly cycles, returns a result res_dly cycles after the last k
    initial begin
        logic [64:0] obs, e;
        pair_ready = 1'b0; res_valid = 1'b0;
        res_c11 = '0; res_c12 = '0; res_c21 = '0; res_c22 = '0;
        forever begin
            @(negedge clk);
            pair_ready = 1'b0;
            res_valid  = 1'b0;
            if (res_pend) begin
                if (res_cnt != 0) begin
                    res_cnt--;
                end else if (res_ready === 1'b1) begin
                    res_valid = 1'b1;
                    res_c11   = 32'(4 * res_n + 1);
                    res_c12   = 32'(4 * res_n + 2);
                    res_c21   = 32'(4 * res_n + 3);
                    res_c22   = 32'(4 * res_n + 4);
                    res_pend  = 1'b0;
                    res_n++;
                end
            end
            if (pair_valid === 1'b1) begin
                obs = {pair_a, pair_b, pair_last};
                if (rdy_wait == 0) hold_pair = obs;
                else check("pair_stable", obs, hold_pair);
                if (rdy_wait < rdy_dly) begin
                    rdy_wait++;
                end else begin
                    pair_ready = 1'b1;
                    rdy_wait   = 0;
                    e = (exp_pair.size() != 0) ? exp_pair.pop_front() : '1;
                    check("pair", obs, e);
                    if (pair_last) begin
                        res_pend = 1'b1;
                        res_cnt  = res_dly;
                    end
                end
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic setup_job(input int sz, input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] cb);
        int t, n;
        logic [31:0] aa, ba;
        t = sz / 2;
        res_n = 0;
        exp_tiles = t * t;
        for (int i = 0; i < t; i++) begin
            for (int j = 0; j < t; j++) begin
                for (int k = 0; k < t; k++) begin
                    aa = ab + 32'(4 * (i * t + k));
                    ba = bb + 32'(4 * (k * t + j));
                    exp_mem.push_back({1'b0, aa, 32'h0});
                    exp_mem.push_back({1'b0, ba, 32'h0});
                    exp_pair.push_back({rd_fn(aa), rd_fn(ba), (k == t - 1)});
                end
                n = i * t + j;
                for (int w = 0; w < 4; w++)
                    exp_mem.push_back({1'b1, cb + 32'(16 * n + 4 * w), 32'(4 * n + w + 1)});
            end
        end
    endtask

    // Leaves the caller at the negedge of the first cycle after the start cycle
    task automatic start_job(input int sz, input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] cb);
        setup_job(sz, ab, bb, cb);
        size = 18'(sz); a_base = ab; b_base = bb; c_base = cb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        int cyc;
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_pulse", 65'(done), 65'(1));
        if (exp_cyc > 0) check("job_cycles", 65'(cyc), 65'(exp_cyc));
        @(negedge clk);
        check("done_width", 65'(done), 65'(0));
        check("busy_after", 65'(busy), 65'(0));
        check("mem_sb_left", 65'(exp_mem.size()), 65'(0));
        check("pair_sb_left", 65'(exp_pair.size()), 65'(0));
        check("tiles_done", 65'(res_n), 65'(exp_tiles));
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ctrl"}, 65'({busy, done, err, mem_req, mem_we, pair_valid, pair_last, res_ready}), 65'(0));
        check({pfx, "_mem"}, 65'({mem_addr, mem_wdata}), 65'(0));
        check({pfx, "_pair"}, 65'({pair_a, pair_b}), 65'(0));
    endtask

    task automatic bad_start(input int sz);
        size = 18'(sz);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bad_done", 65'(done), 65'(1));
        check("bad_err", 65'(err), 65'(1));
        check("bad_req", 65'(mem_req), 65'(0));
        @(negedge clk);
        check("bad_done_end", 65'({done, busy}), 65'(0));
        check("bad_err_hold", 65'(err), 65'(1));
    endtask

    initial begin
        int dbase;
        reset = 1'b1; start = 1'b0; size = '0;
        a_base = '0; b_base = '0; c_base = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // size=2, zero-wait: 15 cycles start to done, first request right after start
        start_job(2, 32'h100, 32'h200, 32'h300);
        check("first_req", 65'({mem_req, mem_addr}), 65'({1'b1, 32'h100}));
        check("busy_run", 65'(busy), 65'(1));
        wait_done(15);

        // size=4 zero-wait: 4 tiles * (2*5 + 1 + 8) + 1
        start_job(4, 32'h100, 32'h200, 32'h300);
        wait_done(77);

        // Backpressure on every handshake
        gnt_dly = 3; rv_dly = 4; rdy_dly = 2; res_dly = 5;
        start_job(4, 32'h100, 32'h200, 32'h300);
        wait_done(0);
        gnt_dly = 0; rv_dly = 0; rdy_dly = 0; res_dly = 0;

        // Illegal sizes, then a good job clears err
        bad_start(3);
        bad_start(0);
        start_job(2, 32'h100, 32'h200, 32'h300);
        check("err_cleared", 65'(err), 65'(0));
        wait_done(15);

        // Reset in WAIT_B with the read response one cycle late
        rv_dly = 1;
        gnt_count = 0;
        start_job(2, 32'h100, 32'h200, 32'h300);
        for (int n = 0; n < 200 && gnt_count < 2; n++) @(posedge clk);
        check("b_granted", 65'(gnt_count), 65'(2));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero("abort");
        exp_mem.delete();
        exp_pair.delete();
        rv_dly = 0;
        @(negedge clk);
        check_zero("late_rvalid");
        repeat (2) @(negedge clk);
        check("idle_after_abort", 65'({busy, mem_req}), 65'(0));
        start_job(2, 32'h100, 32'h200, 32'h300);
        wait_done(15);

        // Start pulses and size change mid-job are ignored
        dbase = done_cnt;
        start_job(2, 32'h100, 32'h200, 32'h300);
        repeat (2) @(negedge clk);
        start = 1'b1;
        size  = 18'd8;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(0);
        repeat (4) @(negedge clk);
        check("single_done", 65'(done_cnt - dbase), 65'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
